wb_write_buffer: RTL and testbench
==================================

Name: wb_write_buffer

Overview:
- Write-back buffer directly upstream of the register file write port. It feeds DstData, WriteReg and WriteEnable, which drive the D and WriteEnable inputs of every bit cell.
- Queues write-back requests from the execute/memory stages when the register-file write port is stalled, and drains one entry per cycle in order.
- Provides youngest-first bypass data for the two source-register read ports, so a read never returns stale register-file contents for a register with a pending write.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- DATA_W, 16, register data width.
- REG_W, 4, register index width (16 registers).

Ports:
- clk  in  1  global clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  write-back request valid.
- in_ready  out  1  buffer can accept a request this cycle.
- in_reg  in  REG_W  destination register of the request.
- in_data  in  DATA_W  write data of the request.
- rf_stall  in  1  register-file write port unavailable this cycle.
- rf_we  out  1  register-file WriteEnable.
- rf_wreg  out  REG_W  register-file WriteReg.
- rf_wdata  out  DATA_W  register-file DstData.
- src_reg1, src_reg2  in  REG_W each  source register indices being read this cycle.
- hit1, hit2  out  1 each  a pending entry targets src_regN.
- byp_data1, byp_data2  out  DATA_W each  data of the youngest matching entry; 0 when there is no hit.
- count  out  clog2(DEPTH)+1  number of occupied entries.
- full, empty  out  1 each  occupancy flags.

Behaviour:
- Reset (rst low, asynchronous), including mid-operation:
  - Head, tail and count go to 0; all entry valid bits are cleared.
  - Output values during and after reset: rf_we=0, rf_wreg=0, rf_wdata=0, in_ready=1, empty=1, full=0, hit1=0, hit2=0, byp_data1=0, byp_data2=0.
  - Any pending writes are discarded.
- Accept rule:
  - in_ready = ~full. It does not depend on in_valid or on the drain of the same cycle; there is no pass-through when full.
  - A push happens when in_valid & in_ready.
- Register 0 is hardwired to zero:
  - A push with in_reg==0 is accepted (the handshake completes) but no entry is allocated; count is unchanged.
  - src_regN==0 never hits.
- Drain:
  - rf_we = ~empty & ~rf_stall, combinational from registered state.
  - rf_wreg and rf_wdata come from the head entry. They are forced to 0 when the buffer is empty.
  - A pop happens on the edge where rf_we=1, and head advances.
- Latency: a request pushed at edge N can appear on rf_we in the cycle after edge N, at the earliest. There is no same-cycle in-to-rf path.
- Pointer wrap: head and tail wrap modulo DEPTH.
- Count update:
  - Push and pop in the same cycle: count is unchanged.
  - Push only: count+1.
  - Pop only: count-1.
- Full/empty boundaries:
  - When full, pushes are refused even if a pop occurs in the same cycle.
  - When empty, rf_we=0 regardless of rf_stall.
- Bypass is combinational:
  - All valid entries are scanned, including the head entry being drained this cycle.
  - The youngest match (closest to tail) wins.
  - An entry pushed in the current cycle is not visible until the next cycle.
- Ordering: multiple pending writes to the same register drain in arrival order, so the last one wins in the register file.

Optional Feature:
- Macro WB_COALESCE_EN.
- When defined:
  - A push whose in_reg equals the register of the youngest valid entry overwrites that entry's data in place. No allocation occurs; count is unchanged.
  - Exception: if that youngest entry is also the head and is popping this cycle, the push allocates normally.
  - Coalescing is permitted while full, so in_ready = ~full | (in_valid & tail-match & ~popping-head). This exception to the accept rule applies only when the macro is defined.
- When undefined: every non-zero push allocates a new entry; the accept rule above applies unchanged.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and REG_W localparams.
  - typedef wb_entry_t {valid, reg, data}.
- Sub-module wb_match:
  - DEPTH-entry CAM compare with a youngest-first priority select, given the tail pointer.
  - Outputs hit and data.
  - Instantiated twice, once per read port.

Test Plan:
- Reset mid-operation: fill 3 entries, assert rst low for 1 cycle -> rf_we=0, count=0, empty=1, hit1=0, and no stale entry drains after release.
- Push R3=0x1234 with rf_stall=0 -> next cycle rf_we=1, rf_wreg=3, rf_wdata=0x1234; the cycle after, empty=1.
- Hold rf_stall=1 and push R1..R4 -> full=1, in_ready=0; a 5th push is refused. Release the stall -> 4 in-order writes on consecutive cycles, and count steps 4,3,2,1,0.
- Pending writes R5=0x00AA (older) and R5=0x00BB (younger) with src_reg1=5 -> hit1=1, byp_data1=0x00BB. With src_reg2=6 -> hit2=0, byp_data2=0.
- Push R0=0xFFFF -> in_ready=1, count stays 0, rf_we never asserts; src_reg1=0 -> hit1=0.
- WB_COALESCE_EN defined, stalled: push R7=0x1, then R7=0x2 -> count=1, and after release a single write of R7=0x2. Without the macro: count=2 and two writes occur.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the entry record for the register-file write-back buffer.
package wb_pkg;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  reg_idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// CAM lookup over the buffer entries; the youngest valid match (closest to tail) wins.
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]      tail,
    input  logic [REG_W-1:0]      src_reg,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest slot to youngest so later (younger) matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int age = DEPTH; age >= 1; age--) begin
            idx = tail - PTR_W'(age);
            if (entries[idx].valid && (entries[idx].reg_idx == src_reg) && (src_reg != '0)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_write_buffer.sv
// In-order write-back queue in front of the register-file write port with read bypass.
// Optional macro WB_COALESCE_EN merges a push into the youngest entry when registers match.
module wb_write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    rf_stall,
    output logic                    rf_we,
    output logic [REG_W-1:0]        rf_wreg,
    output logic [DATA_W-1:0]       rf_wdata,
    input  logic [REG_W-1:0]        src_reg1,
    input  logic [REG_W-1:0]        src_reg2,
    output logic                    hit1,
    output logic                    hit2,
    output logic [DATA_W-1:0]       byp_data1,
    output logic [DATA_W-1:0]       byp_data2,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic pop;
    logic push_fire;
    logic alloc;
    logic coalesce;

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    logic             tail_match;
    logic             pop_youngest;
`endif

    always_comb begin
        full     = (count_q == DEPTH_CNT);
        empty    = (count_q == '0);
        pop      = ~empty & ~rf_stall;
        rf_we    = pop;
        rf_wreg  = empty ? '0 : entries_q[head_q].reg_idx;
        rf_wdata = empty ? '0 : entries_q[head_q].data;
`ifdef WB_COALESCE_EN
        // A merge into the head is unsafe on the edge that head is written out.
        youngest     = tail_q - PTR_W'(1);
        tail_match   = ~empty & (entries_q[youngest].reg_idx == in_reg) & (in_reg != '0);
        pop_youngest = pop & (count_q == CNT_W'(1));
        in_ready     = ~full | (in_valid & tail_match & ~pop_youngest);
        push_fire    = in_valid & in_ready;
        coalesce     = push_fire & tail_match & ~pop_youngest;
`else
        in_ready     = ~full;
        push_fire    = in_valid & in_ready;
        coalesce     = 1'b0;
`endif
        alloc    = push_fire & (in_reg != '0) & ~coalesce;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end
        if (alloc) begin
            entries_d[tail_q].valid   = 1'b1;
            entries_d[tail_q].reg_idx = in_reg;
            entries_d[tail_q].data    = in_data;
            tail_d                    = tail_q + PTR_W'(1);
        end
`ifdef WB_COALESCE_EN
        if (coalesce) begin
            entries_d[youngest].data = in_data;
        end
`endif
        case ({alloc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign count = count_q;

    wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match1 (
        .entries (entries_q),
        .tail    (tail_q),
        .src_reg (src_reg1),
        .hit     (hit1),
        .data    (byp_data1)
    );

    wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match2 (
        .entries (entries_q),
        .tail    (tail_q),
        .src_reg (src_reg2),
        .hit     (hit2),
        .data    (byp_data2)
    );

endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_wb_write_buffer;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_reg;
    logic [DATA_W-1:0] in_data;
    logic              rf_stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_wreg;
    logic [DATA_W-1:0] rf_wdata;
    logic [REG_W-1:0]  src_reg1;
    logic [REG_W-1:0]  src_reg2;
    logic              hit1;
    logic              hit2;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] byp_data2;
    logic [2:0]        count;
    logic              full;
    logic              empty;

    always #5 clk = ~clk;

    wb_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_reg    (in_reg),
        .in_data   (in_data),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_wreg   (rf_wreg),
        .rf_wdata  (rf_wdata),
        .src_reg1  (src_reg1),
        .src_reg2  (src_reg2),
        .hit1      (hit1),
        .hit2      (hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    typedef struct {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
    } mentry_t;

    mentry_t mq[$];
    int checks = 0;
    int errors = 0;

    logic              e_we, e_ready, e_full, e_empty, e_hit1, e_hit2;
    logic [REG_W-1:0]  e_wreg;
    logic [DATA_W-1:0] e_wdata, e_byp1, e_byp2;
    logic [2:0]        e_count;

`ifdef WB_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    // Youngest pending write to a register, as a read port would see it.
    function automatic void lookup(input logic [REG_W-1:0] s, output logic h, output logic [DATA_W-1:0] d);
        h = 1'b0;
        d = '0;
        if (s != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].r == s) begin
                    h = 1'b1;
                    d = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    function automatic logic merges();
        int n = mq.size();
        logic draining = (n > 0) && !rf_stall;
        return COALESCE && (n > 0) && (in_reg != '0) && (mq[n-1].r == in_reg) && !(draining && n == 1);
    endfunction

    function automatic void model_expect();
        int n = mq.size();
        e_count = 3'(n);
        e_empty = (n == 0);
        e_full  = (n == DEPTH);
        e_we    = (n > 0) && !rf_stall;
        e_wreg  = (n > 0) ? mq[0].r : '0;
        e_wdata = (n > 0) ? mq[0].d : '0;
        e_ready = !e_full || (in_valid && merges());
        lookup(src_reg1, e_hit1, e_byp1);
        lookup(src_reg2, e_hit2, e_byp2);
    endfunction

    task automatic drive(input logic v, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d,
                         input logic stall, input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        rf_stall = stall;
        src_reg1 = s1;
        src_reg2 = s2;
        #1;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic advance();
        logic push, pop, coal;
        logic [REG_W-1:0] r;
        logic [DATA_W-1:0] d;
        int n;
        model_expect();
        n    = mq.size();
        push = in_valid && e_ready;
        pop  = e_we;
        coal = push && merges();
        r    = in_reg;
        d    = in_data;
        @(posedge clk);
        if (coal) mq[n-1].d = d;
        else if (push && r != '0) mq.push_back('{r: r, d: d});
        if (pop) void'(mq.pop_front());
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we got %b exp 0", rf_we); end
        checks++; if (rf_wreg !== '0) begin errors++; $display("[TB] FAIL reset_rf_wreg got %h exp 0", rf_wreg); end
        checks++; if (rf_wdata !== '0) begin errors++; $display("[TB] FAIL reset_rf_wdata got %h exp 0", rf_wdata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
        checks++; if (hit1 !== 1'b0 || hit2 !== 1'b0 || byp_data1 !== '0 || byp_data2 !== '0) begin
            errors++; $display("[TB] FAIL reset_bypass got %b %b %h %h exp 0 0 0 0", hit1, hit2, byp_data1, byp_data2);
        end
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
    endtask

    task automatic test_single();
        drive(1'b1, 4'd3, 16'h1234, 1'b0, '0, '0);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL single_no_passthru got %b exp 0", rf_we); end
        advance();
        drive(1'b0, '0, '0, 1'b0, 4'd3, '0);
        checks++; if (rf_we !== 1'b1 || rf_wreg !== 4'd3 || rf_wdata !== 16'h1234) begin
            errors++; $display("[TB] FAIL single_write got we=%b reg=%0d data=%h exp 1 3 1234", rf_we, rf_wreg, rf_wdata);
        end
        checks++; if (hit1 !== 1'b1 || byp_data1 !== 16'h1234) begin
            errors++; $display("[TB] FAIL single_head_bypass got %b %h exp 1 1234", hit1, byp_data1);
        end
        advance();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        checks++; if (empty !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL single_empty got empty=%b we=%b exp 1 0", empty, rf_we); end
    endtask

    task automatic test_fill_stall();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 16'h0100 + 16'(i), 1'b1, '0, '0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready_%0d got %b exp 1", i, in_ready); end
            advance();
        end
        drive(1'b1, 4'd9, 16'h9999, 1'b1, '0, '0);
        checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
            errors++; $display("[TB] FAIL fill_full got full=%b ready=%b count=%0d exp 1 0 4", full, in_ready, count);
        end
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0);
            checks++; if (rf_we !== 1'b1 || rf_wreg !== 4'(k + 1) || rf_wdata !== 16'h0100 + 16'(k + 1) || count !== 3'(4 - k)) begin
                errors++; $display("[TB] FAIL drain_%0d got we=%b reg=%0d data=%h count=%0d exp 1 %0d %h %0d",
                                   k, rf_we, rf_wreg, rf_wdata, count, k + 1, 16'h0100 + 16'(k + 1), 4 - k);
            end
            advance();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_end got count=%0d empty=%b exp 0 1", count, empty); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 4'd5, 16'h00AA, 1'b1, '0, '0); advance();
        drive(1'b1, 4'd5, 16'h00BB, 1'b1, '0, '0); advance();
        drive(1'b0, '0, '0, 1'b1, 4'd5, 4'd6);
        checks++; if (hit1 !== 1'b1 || byp_data1 !== 16'h00BB) begin errors++; $display("[TB] FAIL bypass_young got %b %h exp 1 00bb", hit1, byp_data1); end
        checks++; if (hit2 !== 1'b0 || byp_data2 !== '0) begin errors++; $display("[TB] FAIL bypass_miss got %b %h exp 0 0", hit2, byp_data2); end
        for (int i = 0; i < 4; i++) begin drive(1'b0, '0, '0, 1'b0, '0, '0); advance(); end
    endtask

    task automatic test_reg0();
        drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, '0);
        checks++; if (in_ready !== 1'b1 || hit1 !== 1'b0) begin errors++; $display("[TB] FAIL reg0_accept got ready=%b hit1=%b exp 1 0", in_ready, hit1); end
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, '0, 1'b0, 4'd0, '0);
            checks++; if (count !== 3'd0 || rf_we !== 1'b0 || hit1 !== 1'b0) begin
                errors++; $display("[TB] FAIL reg0_noalloc got count=%0d we=%b hit1=%b exp 0 0 0", count, rf_we, hit1);
            end
            advance();
        end
    endtask

    task automatic test_coalesce();
        int writes = 0;
        logic [DATA_W-1:0] last = '0;
        drive(1'b1, 4'd7, 16'h0001, 1'b1, '0, '0); advance();
        drive(1'b1, 4'd7, 16'h0002, 1'b1, '0, '0); advance();
        drive(1'b0, '0, '0, 1'b1, '0, '0);
        checks++; if (count !== (COALESCE ? 3'd1 : 3'd2)) begin errors++; $display("[TB] FAIL coalesce_count got %0d exp %0d", count, COALESCE ? 1 : 2); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0);
            if (rf_we === 1'b1) begin writes++; last = rf_wdata; end
            advance();
        end
        checks++; if (writes != (COALESCE ? 1 : 2) || last !== 16'h0002) begin
            errors++; $display("[TB] FAIL coalesce_writes got n=%0d last=%h exp %0d 0002", writes, last, COALESCE ? 1 : 2);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin drive(1'b1, 4'(10 + i), 16'hC000 + 16'(i), 1'b1, '0, '0); advance(); end
        drive(1'b0, '0, '0, 1'b1, 4'd10, '0);
        rst = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || hit1 !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset got we=%b count=%0d empty=%b hit1=%b exp 0 0 1 0", rf_we, count, empty, hit1);
        end
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, 4'd10, '0);
            checks++; if (rf_we !== 1'b0 || hit1 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stale_%0d got we=%b hit1=%b exp 0 0", i, rf_we, hit1); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
            model_expect();
            checks++; if (rf_we !== e_we) begin errors++; $display("[TB] FAIL rnd_rf_we c=%0d got %b exp %b", c, rf_we, e_we); end
            checks++; if (rf_wreg !== e_wreg || rf_wdata !== e_wdata) begin
                errors++; $display("[TB] FAIL rnd_head c=%0d got %0d/%h exp %0d/%h", c, rf_wreg, rf_wdata, e_wreg, e_wdata);
            end
            checks++; if (in_ready !== e_ready) begin errors++; $display("[TB] FAIL rnd_ready c=%0d got %b exp %b", c, in_ready, e_ready); end
            checks++; if (count !== e_count || full !== e_full || empty !== e_empty) begin
                errors++; $display("[TB] FAIL rnd_occ c=%0d got %0d %b %b exp %0d %b %b", c, count, full, empty, e_count, e_full, e_empty);
            end
            checks++; if (hit1 !== e_hit1 || byp_data1 !== e_byp1) begin
                errors++; $display("[TB] FAIL rnd_byp1 c=%0d got %b %h exp %b %h", c, hit1, byp_data1, e_hit1, e_byp1);
            end
            checks++; if (hit2 !== e_hit2 || byp_data2 !== e_byp2) begin
                errors++; $display("[TB] FAIL rnd_byp2 c=%0d got %b %h exp %b %h", c, hit2, byp_data2, e_hit2, e_byp2);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_bypass();
        test_reg0();
        test_coalesce();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
